// File: rtl/bcd_seg7_scan.sv
// Multiplexed common-anode 7-segment driver for a packed BCD result.
// Leading-zero blanking, decimal point, anti-ghost blank window, and tear-free frame updates.
module bcd_seg7_scan #(
    parameter int DIGITS    = 7,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  bcd_valid,
    input  logic [2:0]            dp_pos,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic {PH_BLANK, PH_DRIVE} phase_e;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [2:0]          shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [2:0]          disp_dp_q, disp_dp_d;
    logic [6:0]          seg_n_q, seg_n_d;
    logic                dp_n_q, dp_n_d;
    logic [DIGITS-1:0]   dig_n_q, dig_n_d;
    logic                tick_q, tick_d;

    logic       slot_end;
    logic       frame_end;
    phase_e     phase;
    logic [3:0] nib;
    logic       upper_zero;
    logic       dp_valid;
    logic       digit_blank;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        slot_end    = (cnt_q == CNT_LAST);
        frame_end   = slot_end && (idx_q == IDX_LAST);
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        shadow_d    = bcd_valid ? bcd_in : shadow_q;
        shadow_dp_d = bcd_valid ? dp_pos : shadow_dp_q;
        // The display copy takes the pre-edge shadow, so a frame never mixes two values.
        disp_d      = frame_end ? shadow_q : disp_q;
        disp_dp_d   = frame_end ? shadow_dp_q : disp_dp_q;

        phase      = (cnt_q < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
        nib        = 4'd0;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (IDX_W'(j) == idx_q) nib = disp_q[4*j +: 4];
            if (IDX_W'(j) >= idx_q && disp_q[4*j +: 4] != 4'd0) upper_zero = 1'b0;
        end
        dp_valid    = int'(disp_dp_q) < DIGITS;
        digit_blank = (idx_q != '0) && upper_zero
                      && !(dp_valid && int'(idx_q) <= int'(disp_dp_q));

        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        dig_n_d = '1;
        if (phase == PH_DRIVE && !digit_blank) begin
            dig_n_d = ~(DIGITS'(1) << idx_q);
            seg_n_d = seg7_decode(nib);
            dp_n_d  = !(int'(idx_q) == int'(disp_dp_q));
        end
        tick_d = (cnt_q == '0) && (idx_q == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only; the data registers are
    // reset too, because the first frame after reset must read as "0".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= 3'd7;
            disp_q      <= '0;
            disp_dp_q   <= 3'd7;
            seg_n_q     <= 7'h7F;
            dp_n_q      <= 1'b1;
            dig_n_q     <= '1;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
            dig_n_q     <= dig_n_d;
            tick_q      <= tick_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign dig_n      = dig_n_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/bcd_seg7_scan.md
Name: bcd_seg7_scan

Overview:
- Display stage directly downstream of the binary-to-BCD converter in the frequency counter.
- Captures the packed 7-digit BCD result when the converter signals done.
- Drives a time-multiplexed, common-anode 7-segment display with leading-zero blanking, a decimal point, and tear-free frame updates.

Parameters:
- DIGITS, 7, number of BCD digits and display positions; bcd_in width is 4*DIGITS.
- SCAN_DIV, 100000, clock cycles per digit slot; must be >= 2.
- BLANK_CYC, 2000, cycles at the start of each slot with all digits off (anti-ghosting); 0 <= BLANK_CYC < SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- bcd_in  in  4*DIGITS  packed BCD; digit 0 (least significant) is bits [3:0]
- bcd_valid  in  1  1-cycle pulse (converter done); capture bcd_in and dp_pos
- dp_pos  in  3  digit index that lights the decimal point; values >= DIGITS mean no dp
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low
- dig_n  out  DIGITS  digit enables, active-low, one-cold
- frame_tick  out  1  1-cycle pulse when the digit-0 slot begins

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - seg_n = 7'h7F, dp_n = 1, dig_n = all 1s, frame_tick = 0.
  - Slot counter = 0, digit index = 0, shadow and display registers = 0, dp registers = 7 (none).
- Capture: on bcd_valid, the shadow register takes bcd_in and dp_pos on that edge. Captures in later cycles overwrite earlier ones; the last capture wins.
- Frame update: when the digit index wraps to 0 (slot counter reload), the display register loads the shadow register's pre-edge contents.
  - A bcd_valid in that same cycle therefore appears one frame later.
  - A display frame is never mixed between two values.
- Slot counter: counts 0..SCAN_DIV-1 and wraps.
  - At wrap, the digit index increments modulo DIGITS. Scan order is 0,1,...,DIGITS-1,0.
  - frame_tick is asserted for the cycle in which the registered outputs first present digit 0.
- States per slot: BLANK, then DRIVE.
  - BLANK: counter < BLANK_CYC. dig_n = all 1s, seg_n = 7'h7F, dp_n = 1.
  - DRIVE: counter >= BLANK_CYC. dig_n[idx] = 0, all other dig_n bits = 1.
  - With BLANK_CYC = 0, BLANK is skipped.
  - Outputs lag the counter/index by exactly one cycle (registered).
- Decode (seg_n, gfedcba):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex).
  - Nibble 10..15: 3F ('-').
- Leading-zero blanking:
  - Digit i is blank (seg_n = 7F, and its dig_n stays 1 for the whole slot) if every digit j >= i is 0 and i > 0 and i > dp index.
  - Digit 0 is always shown, so the value 0 displays as "0".
  - A digit at or below a valid dp index is never blanked.
  - An invalid nibble counts as non-zero.
- Decimal point: dp_n = 0 only during DRIVE of the digit equal to the latched dp index.
- Reset mid-scan or mid-frame: returns immediately to reset values. The display shows "0" starting from the first frame after reset release.
- Area target: counter width = clog2(SCAN_DIV). No multipliers.

Test Plan:
- Reset: SCAN_DIV=4, BLANK_CYC=1. Hold rst for 3 cycles, then release → all outputs idle during reset; the first frame shows seg_n=40 on digit 0 only; dig_n bits 1..6 stay 1; frame_tick pulses every 28 cycles.
- Normal value: pulse bcd_valid with bcd_in=28'h0012345, dp_pos=7 → next frame shows digit0..4 = 12,19,30,24,79 (5,4,3,2,1); digits 5 and 6 are blanked; dp_n stays 1; each DRIVE lasts 3 cycles, preceded by 1 blank cycle.
- Decimal point: bcd_in=28'h0000007, dp_pos=2 → digits 0..2 show 78,40,40 ("0.07"); dp_n=0 only in the digit-2 DRIVE; digits 3..6 are blanked.
- Tear-free capture: bcd_valid=28'h1111111 during the digit-3 slot, then 28'h2222222 in the digit-6 slot → the remainder of the current frame is unchanged; the next frame shows all 2s (seg_n=24) and never 1s.
- Boundary: assert bcd_valid in the wrap cycle to digit 0 → the new value appears one frame later. A nibble value of 4'hA displays 3F and counts as non-zero for blanking.
- Reset mid-frame: assert rst while digit 4 is driving → dig_n goes to all 1s asynchronously; after release, scanning restarts at digit 0 showing "0".
